huffman_decoder: RTL and testbench

HUFFMAN_DECODER -- requirements
Module: huffman_decoder

---
 rtl/huffman_decoder_if.sv | 51 +++++
 rtl/huffman_decoder.sv | 154 +++++++++++++++
 tb/tb_huffman_decoder.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/huffman_decoder_if.sv
// Bundles the configuration port, the serial code-bit stream and the decoded
// symbol handshake of the canonical Huffman decoder.
interface huffman_decoder_if;
    logic       cfg_we;
    logic       cfg_sel;
    logic [6:0] cfg_addr;
    logic [7:0] cfg_data;
    logic       sync_clr;
    logic       bit_in;
    logic       bit_valid;
    logic       bit_ready;
    logic [6:0] ascii_out;
    logic       ascii_valid;
    logic       ascii_ready;
    logic [3:0] code_len;
    logic       err;

    // Side that loads tables, feeds bits and consumes symbols
    modport master (
        output cfg_we,
        output cfg_sel,
        output cfg_addr,
        output cfg_data,
        output sync_clr,
        output bit_in,
        output bit_valid,
        output ascii_ready,
        input  bit_ready,
        input  ascii_out,
        input  ascii_valid,
        input  code_len,
        input  err
    );

    // Decoder side
    modport slave (
        input  cfg_we,
        input  cfg_sel,
        input  cfg_addr,
        input  cfg_data,
        input  sync_clr,
        input  bit_in,
        input  bit_valid,
        input  ascii_ready,
        output bit_ready,
        output ascii_out,
        output ascii_valid,
        output code_len,
        output err
    );
endinterface

// File: rtl/huffman_decoder.sv
// Serial canonical Huffman decoder. Consumes one code bit per cycle (MSB
// first), tracks the running first-code (f), code value (c) and symbol base
// (b) for the current length, and emits the table symbol on a match.
// Count and symbol tables are written through the cfg port.
module huffman_decoder #(
    parameter int MAX_LEN = 10,
    parameter int NUM_SYM = 96
) (
    input logic         clk,
    input logic         reset,
    huffman_decoder_if.slave dec
);

    localparam logic [3:0]  MAX_LEN_L = 4'(MAX_LEN);
    localparam logic [6:0]  MAX_LEN_A = 7'(MAX_LEN);
    localparam logic [7:0]  NUM_SYM_A = 8'(NUM_SYM);
    localparam logic [11:0] NUM_SYM_I = 12'(NUM_SYM);

    // Per-length code counts (length 0 is implicit and always zero)
    logic [7:0] count_tbl [1:MAX_LEN];
    // Symbols in canonical order
    logic [6:0] sym_tbl [0:NUM_SYM-1];

    // Partial-code tracking
    logic [3:0]  len;
    logic [10:0] c;
    logic [10:0] f;
    logic [6:0]  b;

    // Output registers
    logic [6:0] ascii_q;
    logic       ascii_valid_q;
    logic [3:0] code_len_q;
    logic       err_q;

    // Next-bit datapath
    logic [7:0]  cnt_cur;
    logic [7:0]  cnt_nxt;
    logic [3:0]  len_n;
    logic [10:0] c_n;
    logic [10:0] f_n;
    logic [6:0]  b_n;
    logic [10:0] diff;
    logic [11:0] idx;
    logic [6:0]  sym_rd;
    logic        match;
    logic        idx_ok;
    logic        last_len;
    logic        bit_ready_w;
    logic        accept;

    // Primed values for the incoming bit and the match test against them
    always_comb begin
        cnt_cur  = (len == 4'd0) ? 8'd0 : count_tbl[len];
        len_n    = len + 4'd1;
        cnt_nxt  = count_tbl[len_n];
        c_n      = (c << 1) | {10'd0, dec.bit_in};
        f_n      = (f + {3'b000, cnt_cur}) << 1;
        b_n      = 7'({1'b0, b} + cnt_cur);
        diff     = c_n - f_n;
        match    = (c_n >= f_n) && (diff < {3'b000, cnt_nxt});
        idx      = {5'd0, b_n} + {1'b0, diff};
        idx_ok   = (idx < NUM_SYM_I);
        sym_rd   = sym_tbl[idx[6:0]];
        last_len = (len_n == MAX_LEN_L);
    end

    // A bit is taken only when the output slot is free and nothing else
    // (error, table write, clear, reset) owns the cycle
    always_comb begin
        bit_ready_w = !reset && (!ascii_valid_q || dec.ascii_ready) &&
                      !err_q && !dec.cfg_we && !dec.sync_clr;
        accept      = dec.bit_valid && bit_ready_w;
    end

    // Table storage: cleared by reset, written by cfg_we in any state
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i <= MAX_LEN; i++) begin
                count_tbl[i] <= '0;
            end
            for (int i = 0; i < NUM_SYM; i++) begin
                sym_tbl[i] <= '0;
            end
        end else if (dec.cfg_we) begin
            if (!dec.cfg_sel) begin
                if ((dec.cfg_addr != 7'd0) && (dec.cfg_addr <= MAX_LEN_A)) begin
                    count_tbl[dec.cfg_addr[3:0]] <= dec.cfg_data;
                end
            end else if ({1'b0, dec.cfg_addr} < NUM_SYM_A) begin
                sym_tbl[dec.cfg_addr] <= dec.cfg_data[6:0];
            end
        end
    end

    // Decode progress, symbol holding register and sticky error
    always_ff @(posedge clk) begin
        if (reset) begin
            len           <= '0;
            c             <= '0;
            f             <= '0;
            b             <= '0;
            ascii_q       <= '0;
            ascii_valid_q <= 1'b0;
            code_len_q    <= '0;
            err_q         <= 1'b0;
        end else if (dec.sync_clr) begin
            len           <= '0;
            c             <= '0;
            f             <= '0;
            b             <= '0;
            err_q         <= 1'b0;
            ascii_valid_q <= 1'b0;
        end else begin
            if (ascii_valid_q && dec.ascii_ready) begin
                ascii_valid_q <= 1'b0;
            end
            if (dec.cfg_we) begin
                len <= '0;
                c   <= '0;
                f   <= '0;
                b   <= '0;
            end else if (accept) begin
                if (match && idx_ok) begin
                    ascii_q       <= sym_rd;
                    code_len_q    <= len_n;
                    ascii_valid_q <= 1'b1;
                    len           <= '0;
                    c             <= '0;
                    f             <= '0;
                    b             <= '0;
                end else if (match || last_len) begin
                    err_q <= 1'b1;
                    len   <= '0;
                    c     <= '0;
                    f     <= '0;
                    b     <= '0;
                end else begin
                    len <= len_n;
                    c   <= c_n;
                    f   <= f_n;
                    b   <= b_n;
                end
            end
        end
    end

    assign dec.bit_ready   = bit_ready_w;
    assign dec.ascii_out   = ascii_q;
    assign dec.ascii_valid = ascii_valid_q;
    assign dec.code_len    = code_len_q;
    assign dec.err         = err_q;

endmodule

// File: tb/tb_huffman_decoder.sv
// Bench for huffman_decoder: directed table/stream scenarios with literal
// expectations, then randomized streams against a canonical-Huffman model
// that rebuilds first codes from the count table on every decoded bit.
module tb_huffman_decoder;

    localparam int MAX_LEN = 10;
    localparam int NUM_SYM = 96;

    logic clk = 1'b0;
    logic reset;

    huffman_decoder_if dec_if();

    huffman_decoder #(.MAX_LEN(MAX_LEN), .NUM_SYM(NUM_SYM)) dut (
        .clk   (clk),
        .reset (reset),
        .dec   (dec_if)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int m_cnt [1:MAX_LEN];
    int m_sym [0:NUM_SYM-1];
    int m_val;
    int m_len;
    bit m_valid;
    bit m_err;
    int m_out;
    int m_code_len;

    bit check_en  = 1'b0;
    bit saw_valid = 1'b0;

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_ready();
        return !reset && (!m_valid || dec_if.ascii_ready) && !m_err &&
               !dec_if.cfg_we && !dec_if.sync_clr;
    endfunction

    // Advance the model by one clock edge using the inputs presented to it
    task automatic model_step();
        bit accept;
        bit hit;
        int first;
        int off;
        int idx;
        accept = dec_if.bit_valid && exp_ready();
        if (reset) begin
            for (int i = 1; i <= MAX_LEN; i++) m_cnt[i] = 0;
            for (int i = 0; i < NUM_SYM; i++) m_sym[i] = 0;
            m_val = 0; m_len = 0; m_valid = 0; m_err = 0; m_out = 0; m_code_len = 0;
            return;
        end
        if (dec_if.sync_clr) begin
            m_val = 0; m_len = 0; m_err = 0; m_valid = 0;
        end else begin
            if (m_valid && dec_if.ascii_ready) m_valid = 0;
            if (dec_if.cfg_we) begin
                m_val = 0; m_len = 0;
            end else if (accept) begin
                m_val = m_val * 2 + int'(dec_if.bit_in);
                m_len = m_len + 1;
                first = 0;
                off   = 0;
                for (int l = 1; l < m_len; l++) begin
                    first = (first + m_cnt[l]) * 2;
                    off   = off + m_cnt[l];
                end
                hit = (m_val >= first) && (m_val - first < m_cnt[m_len]);
                if (hit) begin
                    idx = off + m_val - first;
                    if (idx < NUM_SYM) begin
                        m_valid    = 1;
                        m_out      = m_sym[idx];
                        m_code_len = m_len;
                    end else begin
                        m_err = 1;
                    end
                    m_val = 0; m_len = 0;
                end else if (m_len == MAX_LEN) begin
                    m_err = 1;
                    m_val = 0; m_len = 0;
                end
            end
        end
        if (dec_if.cfg_we) begin
            if (!dec_if.cfg_sel) begin
                if (dec_if.cfg_addr >= 1 && int'(dec_if.cfg_addr) <= MAX_LEN)
                    m_cnt[int'(dec_if.cfg_addr)] = int'(dec_if.cfg_data);
            end else if (int'(dec_if.cfg_addr) < NUM_SYM) begin
                m_sym[int'(dec_if.cfg_addr)] = int'(dec_if.cfg_data[6:0]);
            end
        end
    endtask

    task automatic check_output();
        check_val("bit_ready", int'(dec_if.bit_ready), int'(exp_ready()));
        check_val("ascii_valid", int'(dec_if.ascii_valid), int'(m_valid));
        check_val("err", int'(dec_if.err), int'(m_err));
        if (m_valid) begin
            check_val("ascii_out", int'(dec_if.ascii_out), m_out);
            check_val("code_len", int'(dec_if.code_len), m_code_len);
        end
    endtask

    // Compare process: DUT against model every cycle, away from the edge
    always @(negedge clk) begin
        if (check_en) begin
            check_output();
            if (dec_if.ascii_valid) saw_valid = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        dec_if.cfg_we      = 1'b0;
        dec_if.cfg_sel     = 1'b0;
        dec_if.cfg_addr    = '0;
        dec_if.cfg_data    = '0;
        dec_if.sync_clr    = 1'b0;
        dec_if.bit_in      = 1'b0;
        dec_if.bit_valid   = 1'b0;
        dec_if.ascii_ready = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic write_cfg(input logic sel, input logic [6:0] addr, input logic [7:0] data);
        dec_if.bit_valid = 1'b0;
        dec_if.cfg_we    = 1'b1;
        dec_if.cfg_sel   = sel;
        dec_if.cfg_addr  = addr;
        dec_if.cfg_data  = data;
        tick();
        dec_if.cfg_we    = 1'b0;
    endtask

    task automatic load_ref_table();
        write_cfg(1'b0, 7'd1, 8'd1);
        write_cfg(1'b0, 7'd2, 8'd1);
        write_cfg(1'b0, 7'd3, 8'd2);
        write_cfg(1'b1, 7'd0, 8'h41);
        write_cfg(1'b1, 7'd1, 8'h42);
        write_cfg(1'b1, 7'd2, 8'h43);
        write_cfg(1'b1, 7'd3, 8'h44);
    endtask

    task automatic send_code(input logic [9:0] code, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            dec_if.bit_valid = 1'b1;
            dec_if.bit_in    = code[i];
            tick();
        end
        dec_if.bit_valid = 1'b0;
    endtask

    task automatic expect_sym(input string name, input int sym, input int clen);
        check_val({name, " valid"}, int'(dec_if.ascii_valid), 1);
        check_val({name, " ascii"}, int'(dec_if.ascii_out), sym);
        check_val({name, " len"}, int'(dec_if.code_len), clen);
    endtask

    // Random prefix-free table: counts never exceed the free code space
    task automatic load_random_table();
        int first;
        int avail;
        int cnt;
        for (int l = 1; l <= MAX_LEN; l++) write_cfg(1'b0, 7'(l), 8'd0);
        first = 0;
        for (int l = 1; l <= MAX_LEN; l++) begin
            avail = (1 << l) - first;
            cnt   = $urandom_range(0, (avail < 6) ? avail : 6);
            write_cfg(1'b0, 7'(l), 8'(cnt));
            first = (first + cnt) * 2;
        end
        for (int i = 0; i < NUM_SYM; i++) write_cfg(1'b1, 7'(i), 8'($urandom_range(0, 127)));
    endtask

    task automatic apply_stimulus();
        dec_if.bit_valid   = ($urandom_range(0, 3) != 0);
        dec_if.bit_in      = 1'($urandom_range(0, 1));
        dec_if.ascii_ready = ($urandom_range(0, 3) != 0);
        dec_if.sync_clr    = ($urandom_range(0, 59) == 0) || (m_err && $urandom_range(0, 3) == 0);
        dec_if.cfg_we      = ($urandom_range(0, 39) == 0);
        dec_if.cfg_sel     = 1'($urandom_range(0, 1));
        dec_if.cfg_data    = 8'($urandom_range(0, 255));
        if (dec_if.cfg_sel)
            dec_if.cfg_addr = 7'($urandom_range(0, 127));
        else
            dec_if.cfg_addr = ($urandom_range(0, 1) != 0) ? 7'd0 : 7'($urandom_range(11, 127));
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        tick();
        check_val("reset ascii_out", int'(dec_if.ascii_out), 0);
        check_val("reset ascii_valid", int'(dec_if.ascii_valid), 0);
        check_val("reset code_len", int'(dec_if.code_len), 0);
        check_val("reset err", int'(dec_if.err), 0);
        check_val("reset bit_ready", int'(dec_if.bit_ready), 0);
        reset = 1'b0;
        #1;
        check_val("post-reset bit_ready", int'(dec_if.bit_ready), 1);
        check_en = 1'b1;

        // Back-to-back stream 0 | 10 | 110 | 111
        load_ref_table();
        send_code(10'b0, 1);
        expect_sym("A", 8'h41, 1);
        send_code(10'b10, 2);
        expect_sym("B", 8'h42, 2);
        send_code(10'b110, 3);
        expect_sym("C", 8'h43, 3);
        send_code(10'b111, 3);
        expect_sym("D", 8'h44, 3);
        tick();
        check_val("drained valid", int'(dec_if.ascii_valid), 0);

        // Back-pressure holds the symbol and stalls the next bit
        send_code(10'b10, 2);
        expect_sym("held B", 8'h42, 2);
        dec_if.ascii_ready = 1'b0;
        dec_if.bit_valid   = 1'b1;
        dec_if.bit_in      = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("stall bit_ready", int'(dec_if.bit_ready), 0);
            check_val("stall ascii_out", int'(dec_if.ascii_out), 8'h42);
        end
        dec_if.ascii_ready = 1'b1;
        tick();
        dec_if.bit_valid = 1'b0;
        expect_sym("after stall A", 8'h41, 1);

        // Ten unmatched bits raise the sticky error
        do_reset();
        write_cfg(1'b0, 7'd1, 8'd1);
        write_cfg(1'b1, 7'd0, 8'h30);
        saw_valid = 1'b0;
        dec_if.bit_valid = 1'b1;
        dec_if.bit_in    = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 8) check_val("err before 10th", int'(dec_if.err), 0);
        end
        check_val("err after 10th", int'(dec_if.err), 1);
        check_val("err bit_ready", int'(dec_if.bit_ready), 0);
        check_val("err saw_valid", int'(saw_valid), 0);
        dec_if.bit_valid = 1'b0;
        dec_if.sync_clr  = 1'b1;
        tick();
        dec_if.sync_clr  = 1'b0;
        #1;
        check_val("sync_clr err", int'(dec_if.err), 0);
        check_val("sync_clr bit_ready", int'(dec_if.bit_ready), 1);
        send_code(10'b0, 1);
        expect_sym("after clr", 8'h30, 1);

        // Symbol index beyond the table raises err
        do_reset();
        write_cfg(1'b0, 7'd7, 8'd100);
        write_cfg(1'b0, 7'd8, 8'd20);
        write_cfg(1'b1, 7'd5, 8'h55);
        send_code(10'd5, 7);
        expect_sym("len7", 8'h55, 7);
        send_code(10'd200, 8);
        check_val("idx range err", int'(dec_if.err), 1);
        check_val("idx range valid", int'(dec_if.ascii_valid), 0);
        dec_if.sync_clr = 1'b1;
        tick();
        dec_if.sync_clr = 1'b0;

        // Table write discards a partial code
        do_reset();
        load_ref_table();
        send_code(10'b11, 2);
        check_val("partial valid", int'(dec_if.ascii_valid), 0);
        write_cfg(1'b1, 7'd3, 8'h5A);
        send_code(10'b111, 3);
        expect_sym("rewritten D", 8'h5A, 3);

        // Reset in mid-code
        send_code(10'b11, 2);
        reset = 1'b1;
        tick();
        check_val("mid reset ascii_out", int'(dec_if.ascii_out), 0);
        check_val("mid reset ascii_valid", int'(dec_if.ascii_valid), 0);
        check_val("mid reset code_len", int'(dec_if.code_len), 0);
        check_val("mid reset err", int'(dec_if.err), 0);
        check_val("mid reset bit_ready", int'(dec_if.bit_ready), 0);
        tick();
        reset = 1'b0;
        #1;
        check_val("mid reset release ready", int'(dec_if.bit_ready), 1);
        send_code(10'b0, 1);
        check_val("cleared counts", int'(dec_if.ascii_valid), 0);
        dec_if.sync_clr = 1'b1;
        tick();
        dec_if.sync_clr = 1'b0;
        write_cfg(1'b0, 7'd1, 8'd1);
        send_code(10'b0, 1);
        expect_sym("cleared syms", 0, 1);
        tick();
        load_ref_table();
        send_code(10'b110, 3);
        expect_sym("reload C", 8'h43, 3);

        // Randomized streams over several random tables
        for (int r = 0; r < 3; r++) begin
            idle_inputs();
            load_random_table();
            for (int n = 0; n < 1500; n++) begin
                apply_stimulus();
                tick();
            end
        end
        idle_inputs();
        tick();
        tick();

        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
